// File: rtl/mem_ctrl_pkg.sv
// Shared codes for the memory controller: access sizes, FSM states, grant owner
// and bus widths.
package mem_ctrl_pkg;

  localparam int unsigned RamAddrBus = 17;
  localparam int unsigned ByteBus    = 8;

  typedef logic [ByteBus-1:0] byte_bus_t;

  typedef enum logic [1:0] {
    LenByte = 2'd0,
    LenHalf = 2'd1,
    LenWord = 2'd2
  } mem_len_e;

  typedef enum logic [1:0] {
    McIdle  = 2'd0,
    McRead  = 2'd1,
    McWrite = 2'd2
  } mc_state_e;

  typedef enum logic [1:0] {
    GrantNone = 2'd0,
    GrantIf   = 2'd1,
    GrantMem  = 2'd2
  } grant_e;

  // Code 3 is not a legal size and is serviced as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (mem_len_e'(len))
      LenByte: len_bytes = 3'd1;
      LenHalf: len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port controller: arbitrates IF fetches and MEM loads/stores onto a
// byte-wide synchronous RAM, one byte per cycle, little-endian assembly.
//
// state   | meaning
// McIdle  | arbitrate (MEM over IF); no grant while a done pulse is out
// McRead  | issue one address per cycle, capture ram_din one cycle later
// McWrite | one RAM byte write per cycle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW = RamAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  mc_state_e         state_q, state_d;
  grant_e            grant_q, grant_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_AW-1:0] nxt_a;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  byte_bus_t         ram_dout_q, ram_dout_d;
  logic [1:0]        rd_lane, wr_lane;

  // Address arithmetic wraps inside the RAM, so the upper address bits never matter.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  assign nxt_a   = addr_q + RAM_AW'(cnt_q) + RAM_AW'(1);
  assign rd_lane = cnt_q[1:0] - 2'd1;
  assign wr_lane = cnt_q[1:0] + 2'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;

    case (state_q)
      McIdle: begin
        // The finishing requester has not yet presented new parameters.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            grant_d = GrantMem;
            addr_d  = mem_addr[RAM_AW-1:0];
            ram_a_d = mem_addr[RAM_AW-1:0];
            len_d   = len_bytes(mem_len);
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            if (mem_we) begin
              state_d    = McWrite;
              ram_wr_d   = 1'b1;
              ram_dout_d = mem_wdata[7:0];
            end else begin
              state_d = McRead;
            end
          end else if (if_req) begin
            grant_d = GrantIf;
            addr_d  = if_addr[RAM_AW-1:0];
            ram_a_d = if_addr[RAM_AW-1:0];
            len_d   = 3'd4;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = McRead;
          end else begin
            grant_d = GrantNone;
          end
        end
      end

      McRead: begin
        if (cnt_q != 3'd0) buf_d[{rd_lane, 3'b000} +: 8] = ram_din;
        if ((cnt_q + 3'd1) < len_q) ram_a_d = nxt_a;
        if (cnt_q == len_q) begin
          state_d = McIdle;
          grant_d = GrantNone;
          if (grant_q == GrantIf) begin
            if_done_d = 1'b1;
            if_data_d = buf_d;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = buf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      McWrite: begin
        if ((cnt_q + 3'd1) < len_q) begin
          ram_a_d    = nxt_a;
          ram_wr_d   = 1'b1;
          ram_dout_d = mem_wdata[{wr_lane, 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d    = McIdle;
          grant_d    = GrantNone;
          mem_done_d = 1'b1;
        end
      end

      default: begin
        state_d = McIdle;
        grant_d = GrantNone;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= McIdle;
      grant_q     <= GrantNone;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= '0;
      buf_q       <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign if_stall  = if_req & ~if_done_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_stall = mem_req & ~mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed timing sequences, a vector
// table and random accesses checked against an array-based memory model.
module tb_mem_ctrl;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_done, if_stall;
  logic [31:0]   if_addr, if_data;
  logic          mem_req, mem_we, mem_done, mem_stall;
  logic [1:0]    mem_len;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout, ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  logic [7:0]    tb_mem  [MSZ];
  bit            wflag   [MSZ];
  logic [7:0]    ref_mem [MSZ];
  logic          poke_en;
  logic [AW-1:0] poke_a;
  logic [7:0]    poke_v;
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [AW-1:0] tr_a  [16];
  logic          tr_wr [16];
  logic [7:0]    tr_d  [16];
  logic          tr_st [16];

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = (a * 17'd157) ^ (a >> 7) ^ 17'h5A;
    return t[7:0];
  endfunction

  // Synchronous byte RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (poke_en) begin
      tb_mem[poke_a] <= poke_v;
      wflag[poke_a]  <= 1'b1;
    end else if (ram_wr) begin
      tb_mem[ram_a] <= ram_dout;
      wflag[ram_a]  <= 1'b1;
    end
    ram_din <= wflag[ram_a] ? tb_mem[ram_a] : init_byte(ram_a);
  end

  function automatic logic [7:0] ram_now(input logic [31:0] a);
    logic [AW-1:0] t;
    t = a[AW-1:0];
    return wflag[t] ? tb_mem[t] : init_byte(t);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] d;
    logic [31:0] ak;
    d = 32'd0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      d[8*k +: 8] = ref_mem[ak[AW-1:0]];
    end
    return d;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] wd);
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      ref_mem[ak[AW-1:0]] = wd[8*k +: 8];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
    poke_en = 1'b1;
    poke_a  = a;
    poke_v  = v;
    ref_mem[a] = v;
    tick();
    poke_en = 1'b0;
  endtask

  // Called at the start of c0; returns in the done cycle with requests dropped.
  task automatic access(input bit is_if, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_req   = 1'b1;
      mem_we    = we;
      mem_len   = len;
      mem_addr  = addr;
      mem_wdata = wd;
    end
    #1 tr_st[0] = is_if ? if_stall : mem_stall;
    lat = -1;
    rd  = 32'd0;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      tr_a[c]  = ram_a;
      tr_wr[c] = ram_wr;
      tr_d[c]  = ram_dout;
      tr_st[c] = is_if ? if_stall : mem_stall;
      if (is_if ? if_done : mem_done) begin
        lat = c;
        rd  = is_if ? if_data : mem_rdata;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] rd, rd2;
  int          lat, md, id, e;
  bit          saw_done, any_wr;
  bit          r_if, r_we;
  logic [1:0]  r_len;
  logic [31:0] r_a, r_wd;
  int          r_n;
  logic [7:0]  pre [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,          32'h4433_2211, 6};
    vt[1] = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,          32'h0000_0044, 3};
    vt[2] = '{1'b0, 1'b0, 2'd1, 32'h0000_0205, 32'h0,          32'h0000_7766, 4};
    vt[3] = '{1'b0, 1'b0, 2'd3, 32'h0000_0201, 32'h0,          32'h5544_3322, 6};
    vt[4] = '{1'b0, 1'b1, 2'd1, 32'h0000_0300, 32'hCAFE_BABE, 32'h0,          3};
    vt[5] = '{1'b0, 1'b0, 2'd2, 32'h0000_02FF, 32'h0,          32'h5ABA_BE99, 6};
    vt[6] = '{1'b0, 1'b1, 2'd2, 32'h0001_FFFE, 32'h0102_0304, 32'h0,          5};
    vt[7] = '{1'b0, 1'b0, 2'd2, 32'h0001_FFFE, 32'h0,          32'h0102_0304, 6};
    vt[8] = '{1'b1, 1'b0, 2'd2, 32'h0000_0203, 32'h0,          32'h7766_5544, 6};
    vt[9] = '{1'b0, 1'b0, 2'd0, 32'hFFFE_0200, 32'h0,          32'h0000_0011, 3};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    poke_en = 1'b0; poke_a = '0; poke_v = 8'd0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(AW'(i));

    tick(); tick();
    chk("rst_ram_a", 32'(ram_a), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
    pre = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) poke(AW'(32'h200 + i), pre[i]);
    poke(17'h2FF, 8'h99); poke(17'h302, 8'h5A);
    poke(17'h1FFFF, 8'h34); poke(17'h00000, 8'h12);
    tick();

    // IF word fetch: addresses on c1..c4, done on c6, stall through c5
    access(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
    chk("if_word_lat", lat, 6);
    chk("if_word_data", rd, 32'h0000_0513);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("if_word_ram_a_c%0d", k + 1), 32'(tr_a[k+1]), 32'h100 + k);
      chk($sformatf("if_word_ram_wr_c%0d", k + 1), 32'(tr_wr[k+1]), 32'h0);
    end
    for (int c = 0; c <= 6; c++)
      chk($sformatf("if_word_stall_c%0d", c), 32'(tr_st[c]), (c <= 5) ? 32'h1 : 32'h0);
    tick();

    // byte store: one write on c1, done on c2, neighbour untouched
    access(1'b0, 1'b1, 2'd0, 32'h20, 32'hDEAD_BEEF, rd, lat);
    ref_write(32'h20, 1, 32'hDEAD_BEEF);
    chk("st_byte_lat", lat, 2);
    chk("st_byte_ram_a", 32'(tr_a[1]), 32'h20);
    chk("st_byte_ram_wr_c1", 32'(tr_wr[1]), 32'h1);
    chk("st_byte_dout", 32'(tr_d[1]), 32'hEF);
    chk("st_byte_ram_wr_c2", 32'(tr_wr[2]), 32'h0);
    chk("st_byte_mem20", 32'(ram_now(32'h20)), 32'hEF);
    chk("st_byte_mem21", 32'(ram_now(32'h21)), 32'(ref_mem[17'h21]));
    tick();

    // half load straddling the top of RAM
    access(1'b0, 1'b0, 2'd1, 32'h0001_FFFF, 32'h0, rd, lat);
    chk("ld_wrap_lat", lat, 4);
    chk("ld_wrap_data", rd, 32'h0000_1234);
    chk("ld_wrap_ram_a_c1", 32'(tr_a[1]), 32'h1FFFF);
    chk("ld_wrap_ram_a_c2", 32'(tr_a[2]), 32'h00000);
    tick();

    for (int i = 0; i < 10; i++) begin
      access(vt[i].is_if, vt[i].we, vt[i].len, vt[i].addr, vt[i].wd, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      if (vt[i].we) begin
        r_n = nbytes(vt[i].len);
        ref_write(vt[i].addr, r_n, vt[i].wd);
        for (int k = 0; k < r_n; k++)
          chk($sformatf("vec%0d_byte%0d", i, k), 32'(ram_now(vt[i].addr + k)),
              32'(ref_mem[17'(vt[i].addr + k)]));
      end else begin
        chk($sformatf("vec%0d_data", i), rd, vt[i].exp);
      end
      tick();
    end

    // simultaneous requests: MEM first, IF granted the cycle after mem_done
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h200;
    md = -1; id = -1;
    for (int c = 1; c <= 25 && id < 0; c++) begin
      tick();
      if (mem_done && md < 0) begin
        md = c;
        chk("arb_mem_data", mem_rdata, 32'h0000_2211);
        mem_req = 1'b0;
      end
      if (if_done && id < 0) begin
        id = c;
        chk("arb_if_data", if_data, 32'h0000_0513);
      end
    end
    if_req = 1'b0;
    chk("arb_mem_lat", md, 4);
    chk("arb_if_after_mem", id - md, 7);
    tick();

    // back-to-back loads: request held, address changed in the done cycle
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h200;
    md = -1;
    for (int c = 1; c <= 12 && md < 0; c++) begin
      tick();
      if (mem_done) begin
        md = c;
        chk("b2b_data1", mem_rdata, 32'h4433_2211);
      end
    end
    chk("b2b_lat1", md, 6);
    mem_addr = 32'h204;
    tick();
    chk("b2b_no_grant_in_done", 32'(ram_a), 32'h203);
    chk("b2b_done_single", 32'(mem_done), 32'h0);
    tick();
    chk("b2b_second_addr", 32'(ram_a), 32'h204);
    e = -1;
    for (int c = 3; c <= 14 && e < 0; c++) begin
      tick();
      if (mem_done) begin
        e = c;
        chk("b2b_data2", mem_rdata, 32'h8877_6655);
      end
    end
    chk("b2b_lat2", e, 7);
    mem_req = 1'b0;
    tick();

    for (int t = 0; t < 80; t++) begin
      r_if  = ($urandom_range(0, 3) == 0);
      r_we  = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      r_len = r_if ? 2'd2 : 2'($urandom_range(0, 3));
      r_a   = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h0001_FFFC) : $urandom;
      r_wd  = $urandom;
      r_n   = r_if ? 4 : nbytes(r_len);
      access(r_if, r_we, r_len, r_a, r_wd, rd, lat);
      chk($sformatf("rnd%0d_lat", t), lat, (r_we ? r_n + 1 : r_n + 2));
      if (r_we) begin
        ref_write(r_a, r_n, r_wd);
        for (int k = 0; k < r_n; k++)
          chk($sformatf("rnd%0d_byte%0d", t, k), 32'(ram_now(r_a + k)),
              32'(ref_mem[17'(r_a + k)]));
      end else begin
        chk($sformatf("rnd%0d_data", t), rd, ref_read(r_a, r_n));
      end
      tick();
    end

    // make sure a load leaves nonzero read data for the reset check
    access(1'b0, 1'b0, 2'd0, 32'h203, 32'h0, rd2, lat);
    tick();

    // reset sampled on the edge closing c2 of a word store: bytes 0-1 only
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h40; mem_wdata = 32'hA1B2_C3D4;
    saw_done = 1'b0;
    any_wr   = 1'b0;
    tick();
    saw_done |= mem_done;
    tick();
    saw_done |= mem_done;
    rst = 1'b1;
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstmid_ram_wr_c3", 32'(ram_wr), 32'h0);
    chk("rstmid_ram_a_c3", 32'(ram_a), 32'h0);
    chk("rstmid_rdata_cleared", mem_rdata, 32'h0);
    for (int c = 4; c <= 9; c++) begin
      tick();
      saw_done |= mem_done;
      any_wr   |= ram_wr;
    end
    chk("rstmid_no_done", 32'(saw_done), 32'h0);
    chk("rstmid_no_write_after", 32'(any_wr), 32'h0);
    chk("rstmid_byte0", 32'(ram_now(32'h40)), 32'hD4);
    chk("rstmid_byte1", 32'(ram_now(32'h41)), 32'hC3);
    chk("rstmid_byte2", 32'(ram_now(32'h42)), 32'(ref_mem[17'h42]));
    chk("rstmid_byte3", 32'(ram_now(32'h43)), 32'(ref_mem[17'h43]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
